pg_stage_fifo: RTL and testbench
================================

PG_STAGE_FIFO -- requirements
Module: pg_stage_fifo

Interface
REQ-001 Parameter WIDTH, default 4, data word width in bits; legal range 1..64.
REQ-002 Parameter DEPTH, default 4, number of storage entries; power of two, 2..16.
REQ-003 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, synchronous active-high reset, sampled on rising clk.
REQ-005 Port in_valid, input, 1, upstream word present on in_data.
REQ-006 Port in_ready, output, 1, block accepts a word this cycle.
REQ-007 Port in_data, input, WIDTH, upstream word.
REQ-008 Port out_valid, output, 1, head word present on out_data.
REQ-009 Port out_ready, input, 1, downstream consumes head word this cycle.
REQ-010 Port out_data, output, WIDTH, head word; all zeros whenever out_valid is 0.
REQ-011 Port count, output, $clog2(DEPTH)+1, number of occupied entries, 0..DEPTH.
REQ-012 Ports full and empty, output, 1 each, full = (count == DEPTH), empty = (count == 0).

Function
REQ-013 Push occurs in a cycle where in_valid and in_ready are both 1; pop occurs in a cycle where out_valid and out_ready are both 1.
REQ-014 in_ready SHALL be 1 iff full is 0 and rst is 0; no push accepted when full, even if a pop occurs in the same cycle.
REQ-015 out_valid SHALL be 1 iff empty is 0; out_data is driven combinationally from the head entry (first-word fall-through).
REQ-016 Latency: a word pushed at edge N SHALL appear on out_data with out_valid 1 in the cycle following edge N if the FIFO was empty; no same-cycle bypass.
REQ-017 Ordering: words SHALL leave in exactly the order accepted, with no loss or duplication.
REQ-018 Write and read pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 with no extra logic.
REQ-019 Push only: count +1; pop only: count -1; push and pop together: count unchanged, both pointers advance.
REQ-020 When empty, a simultaneous in_valid and out_ready produces push only, since out_valid is 0.
REQ-021 in_valid while in_ready is 0 SHALL leave all state unchanged; upstream holds the word.
REQ-022 out_ready while out_valid is 0 SHALL have no effect.

Reset
REQ-023 On any rising edge with rst = 1: both pointers 0, count 0, out_valid 0, empty 1, full 0, out_data 0.
REQ-024 Reset asserted mid-operation SHALL discard all stored words; any push or pop in that cycle is ignored.
REQ-025 Storage entries SHALL NOT be reset; out_data masking (REQ-010) hides stale contents.
REQ-026 in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-027 Package pg_pkg SHALL hold PG_DEFAULT_WIDTH (4) and PG_DEFAULT_DEPTH (4); the module parameter defaults reference them.
REQ-028 Each storage entry SHALL be one instance of sub-module pg_fifo_slot (parameter WIDTH; ports clk, we, d, q; no reset), instantiated DEPTH times in a generate-for block labelled g_slots.
REQ-029 Pointer, count and flag logic SHALL reside in pg_stage_fifo and be free of latches and combinational loops.

Verification
REQ-030 Reset, then push 0x1,0x2,0x3 with out_ready=0 -> count=3, out_data=0x1, out_valid=1, in_ready=1.
REQ-031 DEPTH=4: push 4 words, hold in_valid=1 with 0x9 -> full=1, in_ready=0, count stays 4; then one pop -> in_ready=1 the next cycle and 0x9 is accepted one cycle later.
REQ-032 Continuous push/pop for 10 words 0x0..0x9 with DEPTH=4 -> output sequence 0x0..0x9 in order, pointers wrap at least twice, count constant once streaming.
REQ-033 Empty, in_valid=1 and out_ready=1 in the same cycle with 0xA -> no pop that cycle; out_valid=1 and out_data=0xA next cycle, count=1.
REQ-034 Count=3, assert rst for one cycle with in_valid=1 and out_ready=1 -> count=0, empty=1, out_data=0, and the word presented during reset is not stored.
REQ-035 Instantiate WIDTH=8, DEPTH=2 and WIDTH=1, DEPTH=16 -> both elaborate, and REQ-030..REQ-033 pass scaled to each depth.

Source files
------------

// File: rtl/pg_pkg.sv
// Shared constants and helpers for the pg staging FIFO.
// Holds parameter defaults and the per-cycle operation encoding.
package pg_pkg;

    // Default data word width in bits.
    localparam int PG_DEFAULT_WIDTH = 4;

    // Default number of storage entries (power of two).
    localparam int PG_DEFAULT_DEPTH = 4;

    // What the FIFO does on a given edge: {push, pop}.
    typedef enum logic [1:0] {
        PG_OP_IDLE = 2'b00,
        PG_OP_POP  = 2'b01,
        PG_OP_PUSH = 2'b10,
        PG_OP_BOTH = 2'b11
    } pg_op_e;

    // Fold the push/pop strobes into one operation code.
    function automatic pg_op_e pg_op(
        input logic push,
        input logic pop
    );
        return pg_op_e'({push, pop});
    endfunction

endpackage

// File: rtl/pg_fifo_slot.sv
// One storage entry of the staging FIFO; no reset on purpose.
// Ports: clk, we (write enable), d (write word), q (stored word).
module pg_fifo_slot
    import pg_pkg::*;
#(
    parameter int WIDTH = PG_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Stale contents are hidden by the read-side mask in the parent.
    always_ff @(posedge clk) begin
        if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pg_stage_fifo.sv
// First-word fall-through staging FIFO with valid/ready on both sides.
// Ports: clk, rst (sync, active high); in_valid/in_ready/in_data
// upstream; out_valid/out_ready/out_data downstream (data zero
// when not valid); count, full, empty occupancy status.
module pg_stage_fifo
    import pg_pkg::*;
#(
    parameter int WIDTH = PG_DEFAULT_WIDTH,
    parameter int DEPTH = PG_DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             push;
    logic             pop;
    pg_op_e           op;
    logic [WIDTH-1:0] slot_q [DEPTH];

    assign full  = (cnt == CNT_FULL);
    assign empty = (cnt == '0);
    assign count = cnt;

    // A full FIFO refuses even when a pop frees a slot this cycle,
    // which keeps in_ready independent of out_ready.
    assign in_ready  = !full && !rst;
    assign out_valid = !empty;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready && !rst;
    assign op   = pg_op(push, pop);

    // Pointers are exactly AW bits so they wrap at DEPTH for free.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case (op)
                PG_OP_PUSH: cnt <= cnt + 1'b1;
                PG_OP_POP:  cnt <= cnt - 1'b1;
                default:    cnt <= cnt;
            endcase
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slots
        pg_fifo_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk (clk),
            .we  (push && (wr_ptr == AW'(i))),
            .d   (in_data),
            .q   (slot_q[i])
        );
    end

    // Head word falls through; masked so unreset slots never leak.
    assign out_data = out_valid ? slot_q[rd_ptr] : '0;

endmodule

// File: tb/tb_pg_stage_fifo.sv
// Testbench for pg_stage_fifo: three configurations, queue model.
// Directed scenarios plus randomized traffic, checked every cycle.
module tb_pg_stage_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iv = 1'b0;
    logic        ordy = 1'b0;
    logic [63:0] din = '0;
    int          cur = 0;

    int compared = 0;
    int mismatched = 0;

    logic        ir [3];
    logic        ov [3];
    logic        fu [3];
    logic        em [3];
    logic [63:0] od [3];
    int          cn [3];

    logic [3:0]  od0;
    logic [7:0]  od1;
    logic [0:0]  od2;
    logic [2:0]  cn0;
    logic [1:0]  cn1;
    logic [4:0]  cn2;

    always #5 clk = ~clk;

    pg_stage_fifo u_d0 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv && cur == 0),
        .in_ready  (ir[0]),
        .in_data   (din[3:0]),
        .out_valid (ov[0]),
        .out_ready (ordy && cur == 0),
        .out_data  (od0),
        .count     (cn0),
        .full      (fu[0]),
        .empty     (em[0])
    );

    pg_stage_fifo #(.WIDTH(8), .DEPTH(2)) u_d1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv && cur == 1),
        .in_ready  (ir[1]),
        .in_data   (din[7:0]),
        .out_valid (ov[1]),
        .out_ready (ordy && cur == 1),
        .out_data  (od1),
        .count     (cn1),
        .full      (fu[1]),
        .empty     (em[1])
    );

    pg_stage_fifo #(.WIDTH(1), .DEPTH(16)) u_d2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv && cur == 2),
        .in_ready  (ir[2]),
        .in_data   (din[0:0]),
        .out_valid (ov[2]),
        .out_ready (ordy && cur == 2),
        .out_data  (od2),
        .count     (cn2),
        .full      (fu[2]),
        .empty     (em[2])
    );

    assign od[0] = 64'(od0);
    assign od[1] = 64'(od1);
    assign od[2] = 64'(od2);
    assign cn[0] = int'(cn0);
    assign cn[1] = int'(cn1);
    assign cn[2] = int'(cn2);

    // Reference model: an ordered queue bounded by the depth.
    logic [63:0] mq [$];
    int          depth;
    logic [63:0] mask;
    int          popped;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s dut%0d: observed %0h expected %0h",
                   tag, cur, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int sz;
        logic [63:0] head;
        sz = mq.size();
        head = (sz > 0) ? mq[0] : 64'd0;
        chk("in_ready", 64'(ir[cur]), 64'(sz < depth && !rst));
        chk("out_valid", 64'(ov[cur]), 64'(sz > 0));
        chk("out_data", od[cur], head);
        chk("count", 64'(cn[cur]), 64'(sz));
        chk("full", 64'(fu[cur]), 64'(sz == depth));
        chk("empty", 64'(em[cur]), 64'(sz == 0));
    endtask

    task automatic step(input logic r, input logic v,
                        input logic [63:0] d, input logic o);
        logic do_push;
        logic do_pop;
        @(negedge clk);
        rst  = r;
        iv   = v;
        din  = d;
        ordy = o;
        #1;
        check_outputs();
        do_push = !r && v && (mq.size() < depth);
        do_pop  = !r && o && (mq.size() > 0);
        @(posedge clk);
        if (r) begin
            mq.delete();
        end else begin
            if (do_pop) begin
                void'(mq.pop_front());
                popped++;
            end
            if (do_push) begin
                mq.push_back(d & mask);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            step(1'b0, 1'b0, 64'd0, 1'b0);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < depth + 2; k++) begin
            step(1'b0, 1'b0, 64'd0, 1'b1);
        end
    endtask

    task automatic run_suite(input int sel, input int dp, input int w);
        cur   = sel;
        depth = dp;
        mask  = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        mq.delete();
        step(1'b1, 1'b0, 64'd0, 1'b0);
        step(1'b1, 1'b0, 64'd0, 1'b0);
        // First cycle after reset: empty, ready to accept.
        step(1'b0, 1'b0, 64'd0, 1'b0);
        chk("post_rst_in_ready", 64'(ir[cur]), 64'd1);

        // Three pushes with the sink stalled.
        step(1'b0, 1'b1, 64'h1, 1'b0);
        step(1'b0, 1'b1, 64'h2, 1'b0);
        step(1'b0, 1'b1, 64'h3, 1'b0);
        idle(1);
        chk("three_push_count", 64'(cn[cur]),
            64'((dp < 3) ? dp : 3));
        chk("three_push_head", od[cur], 64'h1 & mask);
        drain();

        // Fill, hold a refused word, then free one slot.
        for (int k = 0; k < dp; k++) begin
            step(1'b0, 1'b1, 64'(k + 4), 1'b0);
        end
        step(1'b0, 1'b1, 64'h9, 1'b0);
        step(1'b0, 1'b1, 64'h9, 1'b0);
        chk("full_hold_count", 64'(cn[cur]), 64'(dp));
        step(1'b0, 1'b1, 64'h9, 1'b1);
        step(1'b0, 1'b1, 64'h9, 1'b0);
        step(1'b0, 1'b0, 64'h0, 1'b0);
        chk("refill_count", 64'(cn[cur]), 64'(dp));
        drain();

        // Streaming: one in, one out per cycle.
        popped = 0;
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b1, 64'(k), 1'b1);
        end
        drain();
        chk("stream_popped", 64'(popped), 64'd10);

        // Push into an empty FIFO while the sink is ready.
        step(1'b0, 1'b1, 64'hA, 1'b1);
        step(1'b0, 1'b0, 64'h0, 1'b0);
        chk("empty_pushpop_count", 64'(cn[cur]), 64'd1);
        chk("empty_pushpop_data", od[cur], 64'hA & mask);
        drain();

        // Reset mid-operation with both handshakes offered.
        step(1'b0, 1'b1, 64'h1, 1'b0);
        step(1'b0, 1'b1, 64'h2, 1'b0);
        step(1'b0, 1'b1, 64'h3, 1'b0);
        step(1'b1, 1'b1, 64'h5, 1'b1);
        step(1'b0, 1'b0, 64'h0, 1'b0);
        chk("rst_mid_count", 64'(cn[cur]), 64'd0);
        chk("rst_mid_data", od[cur], 64'd0);
        chk("rst_mid_empty", 64'(em[cur]), 64'd1);

        // Random traffic.
        for (int k = 0; k < 200; k++) begin
            step(($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 2) != 0),
                 {$urandom, $urandom},
                 ($urandom_range(0, 2) != 0));
        end
        drain();
        #1;
        check_outputs();
    endtask

    initial begin
        run_suite(0, 4, 4);
        run_suite(1, 2, 8);
        run_suite(2, 16, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
